// File: rtl/vend_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : vend_ctrl                                                    |
// | Purpose : Coin credit accumulation, dispense and greedy change return  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module vend_ctrl #(
    parameter int PRICE_A    = 5,
    parameter int PRICE_B    = 7,
    parameter int MAX_CREDIT = 15,
    parameter int CW         = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    in,
    input  logic          sel,
    input  logic          buy,
    input  logic          cancel,
    output logic          disp_req,
    output logic          disp_sel,
    input  logic          disp_ack,
    output logic          ret_valid,
    output logic [1:0]    ret_coin,
    input  logic          ret_ack,
    output logic [CW-1:0] credit,
    output logic          coin_reject,
    output logic          nack,
    output logic          busy
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_collect  = 2'd1;
    localparam logic [1:0] c_dispense = 2'd2;
    localparam logic [1:0] c_change   = 2'd3;

    localparam logic [CW-1:0] c_price_a = CW'(PRICE_A);
    localparam logic [CW-1:0] c_price_b = CW'(PRICE_B);
    localparam logic [CW-1:0] c_max     = CW'(MAX_CREDIT);

    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_credit, w_credit_nxt;
    logic          r_disp_sel, w_disp_sel_nxt;
    logic          r_coin_reject, w_coin_reject_nxt;
    logic          r_nack, w_nack_nxt;

    logic [CW-1:0] w_coin_val;
    logic [CW-1:0] w_price;
    logic [CW-1:0] w_sum;
    logic [CW-1:0] w_denom;
    logic [1:0]    w_denom_code;
    logic          w_coin_in;

    assign w_coin_in = |in;
    assign w_price   = sel ? c_price_b : c_price_a;
    assign w_sum     = r_credit + w_coin_val;

    always_comb begin
        case (in)
            2'b01:   w_coin_val = CW'(1);
            2'b10:   w_coin_val = CW'(2);
            2'b11:   w_coin_val = CW'(5);
            default: w_coin_val = '0;
        endcase
    end

    // Greedy change: largest denomination not exceeding the remaining credit.
    always_comb begin
        if (r_credit >= CW'(5)) begin
            w_denom      = CW'(5);
            w_denom_code = 2'b11;
        end else if (r_credit >= CW'(2)) begin
            w_denom      = CW'(2);
            w_denom_code = 2'b10;
        end else begin
            w_denom      = CW'(1);
            w_denom_code = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_idle;
            r_credit      <= '0;
            r_disp_sel    <= 1'b0;
            r_coin_reject <= 1'b0;
            r_nack        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_disp_sel    <= w_disp_sel_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_nack        <= w_nack_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_disp_sel_nxt    = r_disp_sel;
        w_coin_reject_nxt = 1'b0;
        w_nack_nxt        = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_coin_in) begin
                    w_credit_nxt = w_coin_val;
                    w_state_nxt  = c_collect;
                end
                w_nack_nxt = buy;
            end
            c_collect: begin
                // Priority cancel > buy > coin; a coin losing arbitration is rejected.
                if (cancel) begin
                    w_state_nxt       = c_change;
                    w_coin_reject_nxt = w_coin_in;
                end else if (buy) begin
                    w_coin_reject_nxt = w_coin_in;
                    if (r_credit >= w_price) begin
                        w_disp_sel_nxt = sel;
                        w_credit_nxt   = r_credit - w_price;
                        w_state_nxt    = c_dispense;
                    end else begin
                        w_nack_nxt = 1'b1;
                    end
                end else if (w_coin_in) begin
                    if (w_sum <= c_max) w_credit_nxt = w_sum;
                    else                w_coin_reject_nxt = 1'b1;
                end
            end
            c_dispense: begin
                w_coin_reject_nxt = w_coin_in;
                if (disp_ack) w_state_nxt = (r_credit != '0) ? c_change : c_idle;
            end
            c_change: begin
                w_coin_reject_nxt = w_coin_in;
                if (ret_ack) begin
                    w_credit_nxt = r_credit - w_denom;
                    if (r_credit == w_denom) w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        disp_req    = (r_state == c_dispense);
        disp_sel    = r_disp_sel;
        ret_valid   = (r_state == c_change);
        ret_coin    = (r_state == c_change) ? w_denom_code : 2'b00;
        credit      = r_credit;
        coin_reject = r_coin_reject;
        nack        = r_nack;
        busy        = (r_state == c_dispense) || (r_state == c_change);
    end

endmodule
`default_nettype wire
